// File: rtl/frv_leak_rng_if.sv
// Seed-load handshake bundle for frv_leak_rng: the requester drives lane/data/valid,
// and the RNG answers with ready.
interface frv_leak_rng_if #(
    parameter int XLEN  = 32,
    parameter int LANES = 2
);
    localparam int LW = (LANES > 1) ? $clog2(LANES) : 1;

    logic            seed_valid;
    logic            seed_ready;
    logic [LW-1:0]   seed_lane;
    logic [XLEN-1:0] seed_data;

    modport master (output seed_valid, seed_lane, seed_data, input seed_ready);
    modport slave  (input seed_valid, seed_lane, seed_data, output seed_ready);
endinterface

// File: rtl/frv_leak_rng.sv
// Multi-lane XNOR-LFSR random source for the leakage barrier; each fence advances all lanes STEPS times.
// Optional macro FRV_LEAK_RNG_ENTROPY_EN adds an entropy_bit input mixed into every feedback bit.
module frv_leak_rng #(
    parameter int              XLEN             = 32,
    parameter int              LANES            = 2,
    parameter logic [XLEN-1:0] TAPS             = 32'h80200003,
    parameter int              STEPS            = 1,
    parameter logic [XLEN-1:0] PRNG_RESET_VALUE = 32'hABCDEF37
) (
    input  logic                  g_clk,
    input  logic                  g_reset,
    input  logic                  leak_fence,
    output logic                  leak_busy,
`ifdef FRV_LEAK_RNG_ENTROPY_EN
    input  logic                  entropy_bit,
`endif
    frv_leak_rng_if.slave         seed,
    output logic [LANES*XLEN-1:0] leak_prng
);

    localparam int CW = $clog2(STEPS + 1);
    localparam logic [CW-1:0] C_STEPS = CW'(STEPS);
    localparam logic [CW-1:0] C_LAST  = CW'(STEPS - 1);
    localparam logic [CW-1:0] C_ONE   = CW'(1);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_STEP = 1'b1;

    logic [0:0]      r_state;
    logic [CW-1:0]   r_cnt;
    logic            r_pend;
    logic [XLEN-1:0] r_lane [LANES];

    logic [XLEN-1:0] w_next [LANES];
    logic            w_step;
    logic            w_ready;
    logic            w_seed_fire;
    logic            w_adv;
    logic            w_ent;

    // Lane i resets to the base value rotated left by 8*i bits.
    function automatic logic [XLEN-1:0] f_rst_val(input int idx);
        int rot;
        rot = (8 * idx) % XLEN;
        if (rot == 0) return PRNG_RESET_VALUE;
        return (PRNG_RESET_VALUE << rot) | (PRNG_RESET_VALUE >> (XLEN - rot));
    endfunction

`ifdef FRV_LEAK_RNG_ENTROPY_EN
    assign w_ent = entropy_bit;
`else
    assign w_ent = 1'b0;
`endif

    assign w_step          = (r_state == ST_STEP);
    assign w_ready         = !g_reset && !w_step;
    assign leak_busy       = !g_reset && w_step;
    assign seed.seed_ready = w_ready;
    assign w_seed_fire     = seed.seed_valid && w_ready;
    assign w_adv           = w_step || leak_fence;

    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            w_next[i] = {r_lane[i][XLEN-2:0], (~^(r_lane[i] & TAPS)) ^ w_ent};
`ifdef FRV_LEAK_RNG_ENTROPY_EN
            // Entropy can steer a lane into the all-ones lockup; recover on the next advance.
            if (&r_lane[i]) w_next[i] = f_rst_val(i);
`endif
        end
    end

    always_ff @(posedge g_clk) begin
        if (g_reset) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_pend  <= 1'b0;
            for (int i = 0; i < LANES; i++) r_lane[i] <= f_rst_val(i);
        end else begin
            for (int i = 0; i < LANES; i++) begin
                if (w_seed_fire && (int'(seed.seed_lane) == i))
                    r_lane[i] <= (&seed.seed_data) ? f_rst_val(i) : seed.seed_data;
                else if (w_adv)
                    r_lane[i] <= w_next[i];
            end

            case (r_state)
                ST_IDLE: begin
                    if (leak_fence) begin
                        r_cnt <= C_LAST;
                        if (STEPS > 1) r_state <= ST_STEP;
                    end
                end
                ST_STEP: begin
                    if (r_cnt == C_ONE) begin
                        // A fence arriving on the final cycle counts as pending.
                        if (r_pend || leak_fence) begin
                            r_cnt  <= C_STEPS;
                            r_pend <= 1'b0;
                        end else begin
                            r_cnt   <= '0;
                            r_state <= ST_IDLE;
                        end
                    end else begin
                        r_cnt <= r_cnt - C_ONE;
                        if (leak_fence) r_pend <= 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    for (genvar g = 0; g < LANES; g++) begin : g_out
        assign leak_prng[g*XLEN +: XLEN] = r_lane[g];
    end

endmodule

// File: doc/frv_leak_rng.md
Name: frv_leak_rng

Overview:
Multi-lane pseudo-random source for the leakage-barrier unit; next generation of the single 32-bit LFSR.
- Generalised in width, lane count, feedback polynomial and steps per fence.
- Adds a seed-load handshake and a busy/pending mechanism for fences.
- Sits beside the leak-fence decode; feeds random words to register-randomisation logic in the writeback path.

Parameters:
XLEN, 32, width of each LFSR lane (min 8).
LANES, 2, number of independent LFSR lanes (1..8).
TAPS, 32'h80200003, feedback tap mask; bit i set = leak_prng bit i participates.
STEPS, 1, LFSR advances per accepted fence (1..16).
PRNG_RESET_VALUE, 32'hABCDEF37, lane 0 reset value; lane i resets to this value rotated left by 8*i bits (mod XLEN).

Ports:
g_clk  input  1  clock, all state on rising edge.
g_reset  input  1  synchronous, active-high reset.
leak_fence  input  1  fence instruction flying past (single-cycle pulse per fence).
leak_busy  output  1  high while stepping is in progress.
seed_valid  input  1  seed write request.
seed_ready  output  1  seed can be accepted this cycle.
seed_lane  input  clog2(LANES) (min 1)  target lane index.
seed_data  input  XLEN  new lane value.
leak_prng  output  LANES*XLEN  current lane values; lane i at bits [i*XLEN +: XLEN].

Behaviour:
- Feedback per lane: fb = ~^(lane & TAPS); next = {lane[XLEN-2:0], fb}. For the defaults this is identical to the XNOR of bits 31, 21, 1 and 0.
- All-ones is the lockup state of this LFSR and is never loaded.
- Reset (g_reset=1 at an edge):
  - each lane takes its reset value;
  - FSM goes to IDLE; step counter = 0; pending = 0;
  - leak_busy = 0; seed_ready = 0 during the reset cycle.
- FSM states IDLE and STEP.
- IDLE:
  - seed_ready = 1.
  - On leak_fence: step counter = STEPS-1, go to STEP.
  - With STEPS=1 and leak_fence in IDLE, all lanes advance once at that edge and the FSM stays in IDLE. This is the legacy single-cycle behaviour with zero busy time.
  - With STEPS>1, all lanes advance on the fence edge and on each following STEP cycle until STEPS advances total have occurred.
- STEP:
  - leak_busy = 1 and seed_ready = 0.
  - All lanes advance every cycle while the counter decrements.
  - When the counter reaches 0 after the final advance, go to IDLE, unless pending is set.
  - If pending is set at that point: clear pending, reload the counter, and continue stepping with no idle gap.
- A fence during STEP sets pending (depth 1). Further fences while pending is set are merged; extra randomness is not required.
- Seed handshake: the transfer occurs when seed_valid && seed_ready.
  - Lane seed_lane is loaded with seed_data at that edge.
  - If seed_data is all-ones, that lane's reset value is loaded instead.
  - seed_lane >= LANES: the transfer completes and no lane changes.
- Seed and fence in the same IDLE cycle:
  - the seeded lane loads seed_data (no advance of that lane at that edge);
  - the other lanes advance normally;
  - the step sequence proceeds as for a plain fence, with its first advance counted.
- leak_prng is registered; lane updates are visible the cycle after the edge.
- Reset mid-STEP aborts the sequence immediately: reset values are loaded and pending is cleared.

Optional Feature:
Macro FRV_LEAK_RNG_ENTROPY_EN.
- Defined: adds input port entropy_bit (1 bit). On every advance, fb for every lane is XORed with entropy_bit. Seeding and lockup substitution are unchanged. Software must tolerate lockup: any lane reaching all-ones is replaced by its reset value on the next advance.
- Undefined: no port; the sequence is purely deterministic as above.

Test Plan:
- Reset, defaults: lane0 = 0xABCDEF37, lane1 = 0xCDEF37AB, leak_busy=0, seed_ready=1 one cycle after reset released.
- STEPS=1, one leak_fence pulse: lane0 = 0x579BDE6E next cycle; leak_busy stays 0 throughout.
- STEPS=4, one fence: leak_busy high for exactly 3 cycles; final lane values equal four single advances per a reference model; seed_ready low during busy.
- STEPS=4, second fence two cycles into STEP: continuous busy for 7 cycles; total 8 advances; a third fence during the pending window adds none.
- Seed lane1 = 0x12345678 in IDLE: lane1 = 0x12345678, lane0 unchanged; then seed lane0 = 0xFFFFFFFF: lane0 = 0xABCDEF37.
- Seed and fence in the same cycle, STEPS=1: seeded lane equals the seed value, other lane advanced once; g_reset asserted mid-STEP restores all reset values next cycle with leak_busy=0.
